// File: rtl/rot_enc_pkg.sv
// Shared types and widths for the rotary-encoder velocity estimator.
package rot_enc_pkg;

  localparam int ENC_W = 32;
  localparam int ERR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } vel_state_t;

endpackage

// File: rtl/rot_enc_hist.sv
// Ring buffer of tick samples. o_oldest is the entry pushed 2^AVG_LOG pushes
// before the push now being offered, so it pairs with the incoming sample.
module rot_enc_hist
  import rot_enc_pkg::*;
#(
  parameter int AVG_LOG = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_clear,
  input  logic                    i_push,
  input  logic signed [ENC_W-1:0] i_data,
  output logic signed [ENC_W-1:0] o_oldest,
  output logic                    o_primed,
  output logic                    o_full
);

  localparam int DEPTH = (1 << AVG_LOG) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic signed [ENC_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]        r_wptr;
  logic [CNT_W-1:0]        r_fill;
  logic [PTR_W-1:0]        w_rptr;
  logic [PTR_W-1:0]        w_wptr_nxt;

  // The slot after the write pointer holds the sample DEPTH-1 pushes old.
  assign w_wptr_nxt = (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
  assign w_rptr     = w_wptr_nxt;
  assign o_oldest   = r_mem[w_rptr];
  assign o_primed   = (r_fill >= CNT_W'(DEPTH - 1));
  assign o_full     = (r_fill == CNT_W'(DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_fill <= '0;
    end else if (i_push) begin
      r_wptr <= w_wptr_nxt;
      if (r_fill != CNT_W'(DEPTH)) r_fill <= r_fill + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (i_push && !i_clear) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/rot_enc_velocity.sv
// Periodic velocity estimator: windowed position delta per sample tick,
// valid/ack hand-off to the host, and a saturating encoder error counter.
module rot_enc_velocity
  import rot_enc_pkg::*;
#(
  parameter int PERIOD_CYCLES = 50000,
  parameter int AVG_LOG       = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sclr,
  input  logic signed [ENC_W-1:0] counter_in,
  input  logic                    error_in,
  input  logic                    ready_in,
  output logic signed [ENC_W-1:0] velocity,
  output logic signed [ENC_W-1:0] position,
  output logic                    vel_valid,
  input  logic                    vel_ack,
  output logic                    overrun,
  output logic                    stale,
  output logic [ERR_W-1:0]        err_count
);

  localparam int TCK_W = $clog2(PERIOD_CYCLES);

  function automatic logic signed [ENC_W-1:0] avg_shift(input logic signed [ENC_W-1:0] d);
    return d >>> AVG_LOG;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (c == {ERR_W{1'b1}}) ? c : c + ERR_W'(1);
  endfunction

  logic [TCK_W-1:0]        r_tick_cnt;
  vel_state_t              r_state;
  vel_state_t              w_state_nxt;
  logic                    w_tick;
  logic                    w_push;
  logic                    w_est;
  logic                    w_clear;
  logic signed [ENC_W-1:0] w_oldest;
  logic signed [ENC_W-1:0] w_delta;
  logic                    w_primed;
  logic                    w_full;
  logic signed [ENC_W-1:0] r_velocity;
  logic signed [ENC_W-1:0] r_position;
  logic                    r_vel_valid;
  logic                    r_overrun;
  logic [ERR_W-1:0]        r_err_count;

  assign w_tick = (r_tick_cnt == TCK_W'(PERIOD_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TCK_W'(1);
  end

  // Losing ready_in empties the history so a restart always refills fully.
  assign w_clear = !ready_in;

  rot_enc_hist #(
    .AVG_LOG (AVG_LOG)
  ) u_hist (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_push   (w_push),
    .i_data   (counter_in),
    .o_oldest (w_oldest),
    .o_primed (w_primed),
    .o_full   (w_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_est       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick && ready_in) begin
          w_push      = 1'b1;
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        if (!ready_in) begin
          w_state_nxt = IDLE;
        end else if (w_tick) begin
          w_push = 1'b1;
          if (w_primed) begin
            w_est       = 1'b1;
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (!ready_in) begin
          w_state_nxt = IDLE;
        end else if (w_tick) begin
          w_push = 1'b1;
          w_est  = w_full;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Modular subtraction keeps the delta correct across the 32-bit wrap.
  assign w_delta = counter_in - w_oldest;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_velocity <= '0;
      r_position <= '0;
    end else if (w_est) begin
      r_velocity <= avg_shift(w_delta);
      r_position <= counter_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        r_vel_valid <= 1'b0;
    else if (w_est)   r_vel_valid <= 1'b1;
    else if (vel_ack) r_vel_valid <= 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                    r_overrun <= 1'b0;
    else if (sclr)                                r_overrun <= 1'b0;
    else if (w_est && r_vel_valid && !vel_ack)    r_overrun <= 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_err_count <= '0;
    else if (sclr)     r_err_count <= '0;
    else if (error_in) r_err_count <= sat_inc(r_err_count);
  end

  assign velocity  = r_velocity;
  assign position  = r_position;
  assign vel_valid = r_vel_valid;
  assign overrun   = r_overrun;
  assign stale     = (r_state != RUN);
  assign err_count = r_err_count;

endmodule

// File: tb/tb_rot_enc_velocity.sv
// Bench for rot_enc_velocity: two instances (AVG_LOG 0 and 2) share stimulus;
// expected estimates are queued when a tick sample is driven and popped after the tick.
module tb_rot_enc_velocity;

  localparam int P = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclr = 1'b0;
  logic error_in = 1'b0;
  logic ready_in = 1'b0;
  logic vel_ack = 1'b1;
  logic signed [31:0] counter_in = '0;

  logic signed [31:0] vel0, pos0, vel2, pos2;
  logic vv0, ov0, st0, vv2, ov2, st2;
  logic [15:0] ec0, ec2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [31:0] vel;
    logic signed [31:0] pos;
  } est_t;

  est_t sb0[$];
  est_t sb2[$];
  logic signed [31:0] hist[$];
  logic exp_vv0, exp_ov0, exp_st0, exp_vv2, exp_ov2, exp_st2;
  logic signed [31:0] last_vel0, last_vel2;

  always #5 clk = ~clk;

  rot_enc_velocity #(.PERIOD_CYCLES(P), .AVG_LOG(0)) u_dut0 (
    .clock(clk), .reset(rst), .sclr(sclr), .counter_in(counter_in),
    .error_in(error_in), .ready_in(ready_in), .velocity(vel0), .position(pos0),
    .vel_valid(vv0), .vel_ack(vel_ack), .overrun(ov0), .stale(st0), .err_count(ec0)
  );

  rot_enc_velocity #(.PERIOD_CYCLES(P), .AVG_LOG(2)) u_dut2 (
    .clock(clk), .reset(rst), .sclr(sclr), .counter_in(counter_in),
    .error_in(error_in), .ready_in(ready_in), .velocity(vel2), .position(pos2),
    .vel_valid(vv2), .vel_ack(vel_ack), .overrun(ov2), .stale(st2), .err_count(ec2)
  );

  task automatic do_reset();
    rst = 1'b1;
    sclr = 1'b0; error_in = 1'b0; ready_in = 1'b0; vel_ack = 1'b1; counter_in = '0;
    hist.delete(); sb0.delete(); sb2.delete();
    exp_vv0 = 0; exp_ov0 = 0; exp_st0 = 1; exp_vv2 = 0; exp_ov2 = 0; exp_st2 = 1;
    last_vel0 = '0; last_vel2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full sample period; ack_tick raises vel_ack only in the tick cycle.
  task automatic period(input logic signed [31:0] val, input bit ack_tick);
    est_t e;
    int n;
    bit est0, est2, ack_pre, ack_at, vb0, vb2;
    n = 0; est0 = 0; est2 = 0;
    ack_pre = vel_ack;
    ack_at = vel_ack | ack_tick;
    counter_in = val;
    if (ready_in) begin
      hist.push_back(val);
      n = hist.size();
      if (n >= 2) begin
        e.vel = val - hist[n-2]; e.pos = val; sb0.push_back(e); est0 = 1;
      end
      if (n >= 5) begin
        e.vel = (val - hist[n-5]) >>> 2; e.pos = val; sb2.push_back(e); est2 = 1;
      end
    end
    vb0 = ack_pre ? 1'b0 : exp_vv0;
    vb2 = ack_pre ? 1'b0 : exp_vv2;
    exp_ov0 = exp_ov0 | (est0 & vb0 & ~ack_at);
    exp_ov2 = exp_ov2 | (est2 & vb2 & ~ack_at);
    exp_vv0 = est0 ? 1'b1 : (ack_at ? 1'b0 : vb0);
    exp_vv2 = est2 ? 1'b1 : (ack_at ? 1'b0 : vb2);
    exp_st0 = !(ready_in && n >= 2);
    exp_st2 = !(ready_in && n >= 5);

    repeat (P-1) @(posedge clk);
    if (ack_tick) begin
      #1 vel_ack = 1'b1;
    end
    @(posedge clk);
    #1;
    vel_ack = ack_pre;

    if (sb0.size() > 0) begin
      e = sb0.pop_front();
      last_vel0 = e.vel;
      checks++;
      if (pos0 !== e.pos) begin errors++; $display("FAIL pos0: got %0d expected %0d", pos0, e.pos); end
    end
    checks++;
    if (vel0 !== last_vel0) begin errors++; $display("FAIL vel0: got %0d expected %0d", vel0, last_vel0); end
    checks++;
    if (vv0 !== exp_vv0) begin errors++; $display("FAIL vv0: got %b expected %b", vv0, exp_vv0); end
    checks++;
    if (ov0 !== exp_ov0) begin errors++; $display("FAIL ov0: got %b expected %b", ov0, exp_ov0); end
    checks++;
    if (st0 !== exp_st0) begin errors++; $display("FAIL st0: got %b expected %b", st0, exp_st0); end

    if (sb2.size() > 0) begin
      e = sb2.pop_front();
      last_vel2 = e.vel;
      checks++;
      if (pos2 !== e.pos) begin errors++; $display("FAIL pos2: got %0d expected %0d", pos2, e.pos); end
    end
    checks++;
    if (vel2 !== last_vel2) begin errors++; $display("FAIL vel2: got %0d expected %0d", vel2, last_vel2); end
    checks++;
    if (vv2 !== exp_vv2) begin errors++; $display("FAIL vv2: got %b expected %b", vv2, exp_vv2); end
    checks++;
    if (ov2 !== exp_ov2) begin errors++; $display("FAIL ov2: got %b expected %b", ov2, exp_ov2); end
    checks++;
    if (st2 !== exp_st2) begin errors++; $display("FAIL st2: got %b expected %b", st2, exp_st2); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (vel0 !== 32'sd0 || pos0 !== 32'sd0) begin errors++; $display("FAIL reset_data0: vel %0d pos %0d expected 0 0", vel0, pos0); end
    checks++;
    if ({vv0, ov0, st0} !== 3'b001) begin errors++; $display("FAIL reset_ctl0: got %b expected 001", {vv0, ov0, st0}); end
    checks++;
    if (ec0 !== 16'h0 || ec2 !== 16'h0) begin errors++; $display("FAIL reset_err: got %h %h expected 0", ec0, ec2); end
    checks++;
    if ({vv2, ov2, st2} !== 3'b001 || vel2 !== 32'sd0) begin errors++; $display("FAIL reset_dut2: ctl %b vel %0d expected 001 0", {vv2, ov2, st2}, vel2); end
  endtask

  task automatic test_ramp();
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 7; i++) period(32'sd3 * i, 1'b0);
    checks++;
    if (vel0 !== 32'sd3 || vel2 !== 32'sd3) begin errors++; $display("FAIL ramp_vel: got %0d %0d expected 3 3", vel0, vel2); end
  endtask

  task automatic test_wrap();
    do_reset();
    ready_in = 1'b1;
    period(32'sh7FFFFFFE, 1'b0);
    period(32'sh80000001, 1'b0);
    checks++;
    if (vel0 !== 32'sd3) begin errors++; $display("FAIL wrap_vel: got %0d expected 3", vel0); end
  endtask

  task automatic test_fall();
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 6; i++) period(-32'sd8 * i, 1'b0);
    checks++;
    if (vel2 !== -32'sd8) begin errors++; $display("FAIL fall_vel2: got %0d expected -8", vel2); end
  endtask

  task automatic test_overrun();
    do_reset();
    ready_in = 1'b1;
    vel_ack = 1'b0;
    period(32'sd0, 1'b0);
    period(32'sd5, 1'b0);
    period(32'sd15, 1'b0);
    checks++;
    if (ov0 !== 1'b1 || vel0 !== 32'sd10) begin errors++; $display("FAIL overrun_set: ov %b vel %0d expected 1 10", ov0, vel0); end
    sclr = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0;
    checks++;
    if (ov0 !== 1'b0 || vv0 !== 1'b1) begin errors++; $display("FAIL overrun_sclr: ov %b vv %b expected 0 1", ov0, vv0); end
    vel_ack = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (vv0 !== 1'b0) begin errors++; $display("FAIL ack_drop: got %b expected 0", vv0); end
  endtask

  task automatic test_ack_collide();
    do_reset();
    ready_in = 1'b1;
    vel_ack = 1'b0;
    period(32'sd0, 1'b0);
    period(32'sd7, 1'b0);
    period(32'sd14, 1'b1);
    checks++;
    if (vv0 !== 1'b1 || ov0 !== 1'b0) begin errors++; $display("FAIL collide: vv %b ov %b expected 1 0", vv0, ov0); end
  endtask

  task automatic test_ready_drop();
    do_reset();
    ready_in = 1'b1;
    period(32'sd0, 1'b0);
    period(32'sd4, 1'b0);
    period(32'sd8, 1'b0);
    vel_ack = 1'b0;
    period(32'sd12, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    ready_in = 1'b0;
    hist.delete();
    exp_st0 = 1'b1; exp_st2 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (st0 !== 1'b1 || st2 !== 1'b1) begin errors++; $display("FAIL drop_stale: got %b %b expected 1 1", st0, st2); end
    checks++;
    if (vel0 !== 32'sd4 || vv0 !== 1'b1) begin errors++; $display("FAIL drop_hold: vel %0d vv %b expected 4 1", vel0, vv0); end
    repeat (4) @(posedge clk);
    #1;
    ready_in = 1'b1;
    vel_ack = 1'b1;
    for (int i = 0; i < 5; i++) period(32'sd20 + 32'sd4 * i, 1'b0);
  endtask

  task automatic test_errors();
    do_reset();
    error_in = 1'b1;
    repeat (5) @(posedge clk);
    #1 error_in = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ec0 !== 16'd5) begin errors++; $display("FAIL err_small: got %0d expected 5", ec0); end
    error_in = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    checks++;
    if (ec0 !== 16'hFFFF || ec2 !== 16'hFFFF) begin errors++; $display("FAIL err_sat: got %h %h expected ffff", ec0, ec2); end
    sclr = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0;
    checks++;
    if (ec0 !== 16'h0) begin errors++; $display("FAIL err_sclr: got %h expected 0", ec0); end
    @(posedge clk); #1;
    error_in = 1'b0;
    checks++;
    if (ec0 !== 16'h1) begin errors++; $display("FAIL err_resume: got %h expected 1", ec0); end
  endtask

  task automatic test_async_reset();
    do_reset();
    ready_in = 1'b1;
    vel_ack = 1'b0;
    period(32'sd0, 1'b0);
    period(32'sd9, 1'b0);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (vel0 !== 32'sd0 || pos0 !== 32'sd0 || vv0 !== 1'b0 || st0 !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: vel %0d pos %0d vv %b st %b expected 0 0 0 1", vel0, pos0, vv0, st0);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_wrap();
    test_fall();
    test_overrun();
    test_ack_collide();
    test_ready_drop();
    test_errors();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rot_enc_velocity.md
# rot_enc_velocity

Periodic velocity estimator downstream of the filtered quadrature encoder counter. It samples the 32-bit signed position count on a fixed tick and forms a windowed delta, in counts per period averaged over 2^AVG_LOG periods. It also counts encoder error pulses and presents each new estimate to the host register bank through a valid/ack handshake.

## Interface
- PERIOD_CYCLES, 50000: clock cycles per sample tick; must be at least 2.
- AVG_LOG, 2: log2 of the averaging window in periods; range 0..4.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sclr  in  1  synchronous clear of err_count and overrun only.
- counter_in  in  32  signed position from the encoder counter.
- error_in  in  1  one-cycle encoder error pulse.
- ready_in  in  1  encoder counter enabled; counter_in is valid while high.
- velocity  out  32  signed windowed delta, arithmetically shifted right by AVG_LOG.
- position  out  32  counter_in value captured at the last tick.
- vel_valid  out  1  a new estimate is pending.
- vel_ack  in  1  consumer accepts the estimate.
- overrun  out  1  sticky; an estimate was overwritten while still pending.
- stale  out  1  high when velocity is not backed by a full window.
- err_count  out  16  saturating count of error_in pulses.

## Operation
- Tick generator:
  - Counter runs 0..PERIOD_CYCLES-1 and wraps.
  - The tick is the cycle where the count equals PERIOD_CYCLES-1.
  - The counter runs free in every state.
- FSM states: IDLE, FILL, RUN.
  - IDLE: history cleared, stale=1. Moves to FILL on the first tick with ready_in=1.
  - FILL: each tick pushes counter_in into the history ring of depth 2^AVG_LOG+1. After 2^AVG_LOG+1 pushes, moves to RUN. The first estimate is produced on that final push.
  - RUN: each tick pushes counter_in and computes the estimate.
  - Any cycle with ready_in=0 in FILL or RUN returns to IDLE immediately. History is cleared, stale=1, and velocity and position hold their last values.
- Estimate arithmetic:
  - The raw delta is counter_in minus the oldest history entry, using 32-bit modular subtraction so wrap past ±2^31 is correct.
  - velocity = raw delta >>> AVG_LOG (arithmetic shift).
  - position = counter_in captured at the tick.
- Handshake:
  - vel_valid rises with each estimate.
  - vel_valid falls on a clock edge where vel_ack=1 and no new estimate is produced in the same cycle.
  - If an estimate is produced while vel_valid=1 and vel_ack=0, the data is overwritten, vel_valid stays 1 and overrun is set.
  - Estimate and ack in the same cycle: the new data is taken, vel_valid stays 1, overrun is not set.
- Error counting:
  - Each error_in=1 cycle increments err_count, saturating at 0xFFFF.
  - sclr clears err_count and overrun; sclr wins over a same-cycle increment or overrun event.
  - error_in is counted in every FSM state.
- Reset values: velocity=0, position=0, vel_valid=0, overrun=0, stale=1, err_count=0, FSM=IDLE, tick counter=0.

## Timing
- counter_in is sampled on the tick cycle T.
- velocity, position, vel_valid and stale update at the clock edge ending T, so they are visible in cycle T+1.
- Latency from a counter change to its visibility in velocity: at most PERIOD_CYCLES+1 cycles.
- Falling ready_in at cycle T: stale=1 and vel_valid is unaffected in T+1. A pending estimate remains readable until acked.
- Asserting reset mid-operation forces the reset values asynchronously.
- After reset releases, the first estimate appears at the (2^AVG_LOG+1)th tick following ready_in=1.

## Structure
- Shared package rot_enc_pkg holds:
  - the FSM state enum (IDLE, FILL, RUN);
  - localparam ENC_W=32;
  - the err_count width constant, 16.
- One sub-module, rot_enc_hist: a ring buffer of depth 2^AVG_LOG+1 with push, clear and oldest-entry read, plus a fill counter that flags full.

## Test plan
- PERIOD_CYCLES=8, AVG_LOG=0, ready_in=1, counter ramps +3 per period -> after 2 ticks vel_valid=1 and velocity=3; stale drops on the first estimate.
- counter_in steps from 0x7FFFFFFE to 0x80000001 across one period, AVG_LOG=0 -> velocity=3.
- AVG_LOG=2, counter falls -8 per period -> first estimate at the 5th tick with velocity=-8; no estimate at ticks 1-4.
- vel_ack held low across two estimates -> overrun=1 and velocity holds the second value; sclr -> overrun=0.
- 70000 error_in pulses -> err_count=0xFFFF; sclr asserted in the same cycle as a pulse -> err_count=0.
- ready_in dropped mid-RUN -> next cycle stale=1 and velocity holds; ready_in re-raised -> the full refill of 2^AVG_LOG+1 ticks precedes the next vel_valid.
